mp_adder_pipe: RTL and testbench

MP_ADDER_PIPE -- requirements
Module: mp_adder_pipe

---
 rtl/mp_adder_pipe.sv | 128 ++++++++++++
 tb/tb_mp_adder_pipe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mp_adder_pipe.sv
// Two-stage SIMD carry-select adder: 4x12 / 2x24 / 1x48 lanes with valid/ready flow.
// S1 holds per-segment generate/propagate and both pre-sums; S2 resolves lookahead carries.

module mp_adder_seg #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         g,
  output logic         p,
  output logic [W-1:0] sum0,
  output logic [W-1:0] sum1
);
  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign g    = full[W];
  assign p    = &(a ^ b);
  assign sum0 = full[W-1:0];
  assign sum1 = full[W-1:0] + {{(W-1){1'b0}}, 1'b1};
endmodule

module mp_adder_pipe #(
  parameter int ADDER_WIDTH = 48,
  parameter int SEG_WIDTH   = 12
) (
  input  logic                   iClk,
  input  logic                   iRstn,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [ADDER_WIDTH-1:0] iA,
  input  logic [ADDER_WIDTH-1:0] iB,
  input  logic                   iC,
  input  logic [1:0]             iMode,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [ADDER_WIDTH-1:0] oSum,
  output logic [3:0]             oC
);
  localparam int NSEG = ADDER_WIDTH / SEG_WIDTH;

  typedef struct packed {
    logic [NSEG-1:0]                g;
    logic [NSEG-1:0]                p;
    logic [NSEG-1:0][SEG_WIDTH-1:0] sum0;
    logic [NSEG-1:0][SEG_WIDTH-1:0] sum1;
    logic                           cin;
    logic [1:0]                     mode;
  } s1_t;

  logic [NSEG-1:0]                seg_g, seg_p;
  logic [NSEG-1:0][SEG_WIDTH-1:0] seg_s0, seg_s1;
  s1_t                            s1_d, s1_q;
  logic [2:1]                     vld_pipe;
  logic                           adv, accept;
  logic [NSEG-1:0][SEG_WIDTH-1:0] sum_d;
  logic [3:0]                     oc_d;
  logic                           c_run, c_nxt;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    mp_adder_seg #(.W(SEG_WIDTH)) u_seg (
      .a    (iA[k*SEG_WIDTH +: SEG_WIDTH]),
      .b    (iB[k*SEG_WIDTH +: SEG_WIDTH]),
      .g    (seg_g[k]),
      .p    (seg_p[k]),
      .sum0 (seg_s0[k]),
      .sum1 (seg_s1[k])
    );
  end

  always_comb begin
    s1_d.g    = seg_g;
    s1_d.p    = seg_p;
    s1_d.sum0 = seg_s0;
    s1_d.sum1 = seg_s1;
    s1_d.cin  = iC;
    s1_d.mode = iMode;
  end

  // Lane geometry: mode 00 = every segment is a lane, 01 = pairs, 1x = one lane.
  function automatic logic seg_start(input logic [1:0] m, input int k);
    return (m == 2'b00) || (m == 2'b01 && (k % (NSEG/2)) == 0) || (k == 0);
  endfunction

  function automatic logic seg_end(input logic [1:0] m, input int k);
    return (m == 2'b00) || (m == 2'b01 && ((k + 1) % (NSEG/2)) == 0) || (k == NSEG-1);
  endfunction

  assign adv    = !vld_pipe[2] || iReady;
  assign oReady = !vld_pipe[1] || adv;
  assign accept = iValid && oReady;
  assign oValid = vld_pipe[2];

  always_comb begin
    c_run = s1_q.cin;
    c_nxt = 1'b0;
    sum_d = '0;
    oc_d  = '0;
    for (int k = 0; k < NSEG; k++) begin
      if (seg_start(s1_q.mode, k)) c_run = s1_q.cin;
      sum_d[k] = c_run ? s1_q.sum1[k] : s1_q.sum0[k];
      c_nxt    = s1_q.g[k] | (s1_q.p[k] & c_run);
      if (seg_end(s1_q.mode, k)) oc_d[k] = c_nxt;
      c_run    = c_nxt;
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      oSum     <= '0;
      oC       <= '0;
    end else begin
      if (accept) s1_q <= s1_d;
      if (accept)   vld_pipe[1] <= 1'b1;
      else if (adv) vld_pipe[1] <= 1'b0;
      if (adv) begin
        vld_pipe[2] <= vld_pipe[1];
        // Bubbles leave the last result on oSum/oC; only real data overwrites.
        if (vld_pipe[1]) begin
          oSum <= sum_d;
          oC   <= oc_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_mp_adder_pipe.sv
// Randomised bench for mp_adder_pipe: lane-wise arithmetic model, scoreboard queue,
// directed vectors, backpressure hold, back-to-back throughput and mid-flight reset.

module tb_mp_adder_pipe;
  logic        iClk = 1'b0, iRstn = 1'b0, iValid = 1'b0, iC = 1'b0, iReady = 1'b0;
  logic        oReady, oValid;
  logic [47:0] iA = '0, iB = '0, oSum;
  logic [1:0]  iMode = 2'b00;
  logic [3:0]  oC;

  int          n_vec = 0, n_err = 0, n_acc = 0, cyc = 0;
  logic [51:0] exp_q[$];
  int          out_cyc[$];
  logic        hold = 1'b0;
  logic [51:0] held;

  always #5 iClk = ~iClk;

  mp_adder_pipe #(.ADDER_WIDTH(48), .SEG_WIDTH(12)) dut (
    .iClk(iClk), .iRstn(iRstn), .iValid(iValid), .oReady(oReady),
    .iA(iA), .iB(iB), .iC(iC), .iMode(iMode),
    .oValid(oValid), .iReady(iReady), .oSum(oSum), .oC(oC)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lane-wise reference: add each lane independently, wrap, report lane carry at its top segment.
  function automatic logic [51:0] model(input logic [47:0] a, input logic [47:0] b,
                                        input logic c, input logic [1:0] m);
    int          lw;
    logic [63:0] mask, t, s;
    logic [3:0]  oc;
    lw = (m == 2'b00) ? 12 : (m == 2'b01) ? 24 : 48;
    mask = (64'd1 << lw) - 64'd1;
    s = '0;
    oc = '0;
    for (int off = 0; off < 48; off += lw) begin
      t = ((64'(a) >> off) & mask) + ((64'(b) >> off) & mask) + 64'(c);
      s |= (t & mask) << off;
      oc[(off + lw) / 12 - 1] = t[lw];
    end
    return {oc, s[47:0]};
  endfunction

  function automatic logic [47:0] rnd48();
    logic [47:0] v;
    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(0, 4))
        0:       v[k*12 +: 12] = 12'hFFF;
        1:       v[k*12 +: 12] = 12'h000;
        2:       v[k*12 +: 12] = 12'h001;
        default: v[k*12 +: 12] = 12'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic rnd_inputs();
    iA = rnd48(); iB = rnd48(); iC = 1'($urandom); iMode = 2'($urandom);
  endtask

  // Scoreboard/monitor, sampled on the falling edge.
  always @(negedge iClk) begin
    cyc++;
    if (!iRstn) begin
      exp_q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_data", 64'({oC, oSum}), 64'(held));
        chk("hold_valid", 64'(oValid), 64'd1);
      end
      hold = oValid && !iReady;
      held = {oC, oSum};
      if (oValid && iReady) begin
        if (exp_q.size() == 0) chk("spurious_valid", 64'(oValid), 64'd0);
        else chk("result", 64'({oC, oSum}), 64'(exp_q.pop_front()));
        out_cyc.push_back(cyc);
      end
      if (iValid && oReady) begin
        exp_q.push_back(model(iA, iB, iC, iMode));
        n_acc++;
      end
    end
  end

  // Presents current inputs; returns 1 ns after the accepting edge.
  task automatic send();
    int n = 0;
    iValid = 1'b1;
    @(negedge iClk);
    while (!oReady && n < 50) begin @(negedge iClk); n++; end
    if (!oReady) chk("send_timeout", 64'(oReady), 64'd1);
    @(posedge iClk); #1;
  endtask

  task automatic drain();
    int n = 0;
    iValid = 1'b0; iReady = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin @(posedge iClk); #1; n++; end
    repeat (2) @(posedge iClk);
    #1 chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int a0, q0;
    #12;
    chk("rst_valid", 64'(oValid), 64'd0);
    chk("rst_sum", 64'(oSum), 64'd0);
    chk("rst_carry", 64'(oC), 64'd0);
    chk("rst_ready", 64'(oReady), 64'd1);

    // First edge after release accepts; result two cycles on.
    @(posedge iClk); #2 iRstn = 1'b1; iReady = 1'b1;
    iMode = 2'b10; iA = 48'hFFFF_FFFF_FFFF; iB = 48'd1; iC = 1'b0; iValid = 1'b1;
    @(posedge iClk); #1 iValid = 1'b0;
    chk("lat_stage1", 64'(oValid), 64'd0);
    @(posedge iClk); #1;
    chk("lat_stage2", 64'(oValid), 64'd1);
    chk("wrap48", 64'({oC, oSum}), 64'({4'b1000, 48'h0}));

    iMode = 2'b00; iA = 48'hFFF_000_FFF_001; iB = 48'h001_000_001_FFF; iC = 1'b0;
    send(); iValid = 1'b0;
    @(posedge iClk); #1;
    chk("quad12", 64'({oC, oSum}), 64'({4'b1011, 48'h0}));

    iMode = 2'b01; iA = 48'h000FFF_FFFFFF; iB = 48'h000001_000000; iC = 1'b1;
    send(); iValid = 1'b0;
    iMode = 2'b11; iA = 48'h7FFF_FFFF_FFFF; iB = 48'h0000_0000_0001; iC = 1'b1;
    send(); iValid = 1'b0;
    drain();

    // Four back-to-back with mode changes: steady ready, consecutive results.
    q0 = out_cyc.size();
    for (int i = 0; i < 4; i++) begin
      rnd_inputs(); iMode = 2'(i);
      send();
      chk("b2b_ready", 64'(oReady), 64'd1);
    end
    drain();
    chk("b2b_count", 64'(out_cyc.size() - q0), 64'd4);
    for (int i = q0 + 1; i < out_cyc.size(); i++)
      chk("b2b_consec", 64'(out_cyc[i] - out_cyc[i-1]), 64'd1);

    // Backpressure: three offers, only two fit.
    iReady = 1'b0; a0 = n_acc;
    rnd_inputs(); iValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge iClk); #1;
      if (n_acc - a0 >= 3) iValid = 1'b0; else rnd_inputs();
    end
    chk("bp_accepts", 64'(n_acc - a0), 64'd2);
    chk("bp_ready", 64'(oReady), 64'd0);
    iReady = 1'b1;
    @(posedge iClk); #1 iValid = 1'b0;
    drain();
    chk("bp_total", 64'(n_acc - a0), 64'd3);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      iValid = ($urandom_range(0, 3) != 0);
      iReady = ($urandom_range(0, 3) != 0);
      rnd_inputs();
      @(posedge iClk); #1;
    end
    drain();

    // Reset with two in flight.
    iReady = 1'b0;
    rnd_inputs(); send();
    rnd_inputs(); send();
    iValid = 1'b0;
    #2 iRstn = 1'b0;
    #1;
    chk("midrst_valid", 64'(oValid), 64'd0);
    chk("midrst_sum", 64'(oSum), 64'd0);
    chk("midrst_carry", 64'(oC), 64'd0);
    @(posedge iClk); @(posedge iClk); #2 iRstn = 1'b1; iReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge iClk); #1 chk("post_rst_valid", 64'(oValid), 64'd0);
    end
    for (int i = 0; i < 50; i++) begin
      iValid = 1'($urandom); iReady = ($urandom_range(0, 2) != 0);
      rnd_inputs();
      @(posedge iClk); #1;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
